vector_fork_seq: RTL and testbench
==================================

VECTOR_FORK_SEQ -- requirements
Module: vector_fork_seq

Interface
REQ-001 SHALL have parameter N, default 32, element width in bits.
REQ-002 SHALL have parameter V, default 20, elements per vector register.
REQ-003 SHALL have parameter L, default 4, parallel lanes; STEPS = ceil(V/L).
REQ-004 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port RST  input  1  synchronous, active-low reset.
REQ-006 SHALL have port Start_i  input  1  request to capture operands and begin a sequence.
REQ-007 SHALL have port OpType  input  2  bit0: 1 = vector-vector, 0 = vector-scalar; bit1: 1 = reverse step order.
REQ-008 SHALL have port RD1_VEC_i  input  V x N  operand-A vector.
REQ-009 SHALL have port RD2_VEC_i  input  V x N  operand-B vector.
REQ-010 SHALL have port Scalar_i  input  N  broadcast operand B in vector-scalar mode.
REQ-011 SHALL have port Ready_i  input  1  downstream ALU accepts the current beat.
REQ-012 SHALL have port Valid_o  output  1  current beat valid.
REQ-013 SHALL have port Vec_A_o / Vec_B_o  output  L x N each  lane operands.
REQ-014 SHALL have port Lane_Mask_o  output  L  per-lane element-valid.
REQ-015 SHALL have port Step_o  output  clog2(STEPS)  current step index.
REQ-016 SHALL have ports Last_o, Busy_o, Done_o  output  1 each  final beat, sequence active, one-cycle completion pulse.

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> DONE -> IDLE.
REQ-018 SHALL accept Start_i only in IDLE; accepted Start_i SHALL register RD1_VEC_i, RD2_VEC_i, Scalar_i, OpType, enter ISSUE next cycle.
REQ-019 SHALL ignore Start_i in ISSUE and DONE; captured operands SHALL not change until next acceptance.
REQ-020 SHALL assert Valid_o exactly while in ISSUE; first beat one cycle after accepted Start_i.
REQ-021 SHALL, at step s, drive lane j with element index e = j*STEPS + s: Vec_A_o[j] = A[e]; Vec_B_o[j] = B[e] when OpType[0]=1, else Scalar.
REQ-022 SHALL set Lane_Mask_o[j] = (e < V); lanes with e >= V SHALL drive zero on Vec_A_o[j] and Vec_B_o[j].
REQ-023 SHALL start step at 0 and increment (OpType[1]=0), or start at STEPS-1 and decrement (OpType[1]=1).
REQ-024 SHALL advance step only on Valid_o & Ready_i; with Ready_i low all beat outputs SHALL hold stable.
REQ-025 SHALL assert Last_o with Valid_o on the final step (STEPS-1 forward, 0 reverse).
REQ-026 SHALL move to DONE on Valid_o & Ready_i & Last_o; Done_o SHALL be high for exactly the DONE cycle, then IDLE.
REQ-027 SHALL drive Busy_o = (state != IDLE).
REQ-028 SHALL drive Vec_A_o, Vec_B_o, Lane_Mask_o, Step_o, Last_o to zero outside ISSUE.
REQ-029 SHALL handle STEPS = 1 (V <= L): single beat with Last_o high.

Reset
REQ-030 SHALL, with RST=0 at a rising edge, enter IDLE, clear step counter and captured registers, drive all outputs 0.
REQ-031 SHALL abort an in-progress sequence on reset without Done_o.
REQ-032 SHALL give reset priority over Start_i and Ready_i in the same cycle.

Structure
REQ-033 SHALL place FSM state enum, OpType bit-position constants and the STEPS ceiling function in shared package vector_pkg.
REQ-034 SHALL implement per-lane element select and zero-masking in one sub-module lane_select, instantiated L times.

Verification
REQ-035 SHALL cover: V=20,L=4, RD1[i]=i, RD2[i]=100+i, OpType=01, Ready_i=1 -> step0 A={0,5,10,15}, B={100,105,110,115}; five beats; Last_o on 5th; Done_o next cycle.
REQ-036 SHALL cover: OpType=00, Scalar_i=7 -> every beat B={7,7,7,7}, A as above.
REQ-037 SHALL cover: Ready_i low 3 cycles at step 2 -> outputs held at A={2,7,12,17}, Step_o=2; resume advances to step 3.
REQ-038 SHALL cover: V=18,L=4 -> STEPS=5; step4 A={4,9,14,0}, Lane_Mask_o=0111.
REQ-039 SHALL cover: OpType=11 -> first beat Step_o=4, A={4,9,14,19}; Last_o at Step_o=0.
REQ-040 SHALL cover: RST=0 at step 3, also Start_i during ISSUE -> ignored Start_i changes nothing; reset gives IDLE, all outputs 0, no Done_o.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared definitions for the vector fork sequencer.
//   state_t    : sequencer FSM states
//   OP_*_BIT   : bit positions inside the 2-bit OpType field
//   ceil_div() : integer ceiling division (used to derive STEPS = ceil(V/L))
package vector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int unsigned OP_VV_BIT  = 0;  // 1 = vector-vector, 0 = vector-scalar
    localparam int unsigned OP_REV_BIT = 1;  // 1 = walk steps from STEPS-1 down to 0

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/lane_select.sv
// Element selector for one output lane of vector_fork_seq.
// At step s the lane presents element e = LANE*STEPS + s of the captured
// operand vectors; elements past the end of the vector (e >= V) and any
// cycle with en low produce zero data and a cleared valid bit.
//   en      : sequencer is issuing beats
//   vv      : 1 = operand B from b_vec, 0 = broadcast scalar
//   step    : current step index
//   a_vec   : captured operand-A vector
//   b_vec   : captured operand-B vector
//   scalar  : captured scalar operand
//   a, b    : lane operands
//   valid   : lane carries a real element
module lane_select #(
    parameter int unsigned N     = 32,
    parameter int unsigned V     = 20,
    parameter int unsigned STEPS = 5,
    parameter int unsigned LANE  = 0,
    parameter int unsigned SW    = 3
) (
    input  logic                en,
    input  logic                vv,
    input  logic [SW-1:0]       step,
    input  logic [V-1:0][N-1:0] a_vec,
    input  logic [V-1:0][N-1:0] b_vec,
    input  logic [N-1:0]        scalar,
    output logic [N-1:0]        a,
    output logic [N-1:0]        b,
    output logic                valid
);

    localparam int unsigned IW = (V > 1) ? $clog2(V) : 1;

    int unsigned e;

    always_comb begin
        e     = LANE * STEPS + 32'(step);
        a     = '0;
        b     = '0;
        valid = 1'b0;
        if (en && (e < V)) begin
            valid = 1'b1;
            // Compare-and-select keeps the index in range for every parameter set.
            for (int unsigned i = 0; i < V; i++) begin
                if (i == e) begin
                    a = a_vec[IW'(i)];
                    b = vv ? b_vec[IW'(i)] : scalar;
                end
            end
        end
    end

endmodule

// File: rtl/vector_fork_seq.sv
// Vector fork sequencer: captures two V-element operand vectors (or one
// vector plus a broadcast scalar) and feeds them to an L-lane ALU over
// STEPS = ceil(V/L) beats with a valid/ready handshake.
//   CLK, RST          : clock, synchronous active-low reset
//   Start_i           : capture operands and begin a sequence (IDLE only)
//   OpType            : bit0 vector-vector, bit1 reverse step order
//   RD1_VEC_i         : operand-A vector
//   RD2_VEC_i         : operand-B vector
//   Scalar_i          : broadcast operand B in vector-scalar mode
//   Ready_i           : downstream accepts the current beat
//   Valid_o           : beat valid (high throughout ISSUE)
//   Vec_A_o, Vec_B_o  : lane operands
//   Lane_Mask_o       : per-lane element valid
//   Step_o            : current step index
//   Last_o            : final beat of the sequence
//   Busy_o            : sequence active
//   Done_o            : one-cycle completion pulse
module vector_fork_seq
    import vector_pkg::*;
#(
    parameter int unsigned N = 32,
    parameter int unsigned V = 20,
    parameter int unsigned L = 4,
    localparam int unsigned STEPS = ceil_div(V, L),
    localparam int unsigned SW    = (STEPS > 1) ? $clog2(STEPS) : 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                Start_i,
    input  logic [1:0]          OpType,
    input  logic [V-1:0][N-1:0] RD1_VEC_i,
    input  logic [V-1:0][N-1:0] RD2_VEC_i,
    input  logic [N-1:0]        Scalar_i,
    input  logic                Ready_i,
    output logic                Valid_o,
    output logic [L-1:0][N-1:0] Vec_A_o,
    output logic [L-1:0][N-1:0] Vec_B_o,
    output logic [L-1:0]        Lane_Mask_o,
    output logic [SW-1:0]       Step_o,
    output logic                Last_o,
    output logic                Busy_o,
    output logic                Done_o
);

    localparam logic [SW-1:0] STEP_MAX = SW'(STEPS - 1);

    state_t               state_q, state_d;
    logic [SW-1:0]        step_q;
    logic [V-1:0][N-1:0]  a_q, b_q;
    logic [N-1:0]         scalar_q;
    logic [1:0]           op_q;
    logic                 issue;
    logic                 is_last;

    assign issue = (state_q == ST_ISSUE);

    always_comb begin
        is_last = 1'b0;
        if (issue) begin
            is_last = op_q[OP_REV_BIT] ? (step_q == '0) : (step_q == STEP_MAX);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (Start_i) state_d = ST_ISSUE;
            ST_ISSUE: if (Ready_i && is_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            scalar_q <= '0;
            op_q     <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && Start_i) begin
                a_q      <= RD1_VEC_i;
                b_q      <= RD2_VEC_i;
                scalar_q <= Scalar_i;
                op_q     <= OpType;
                step_q   <= OpType[OP_REV_BIT] ? STEP_MAX : '0;
            end else if (issue && Ready_i) begin
                // Counter parks at zero after the final beat.
                if (is_last)
                    step_q <= '0;
                else if (op_q[OP_REV_BIT])
                    step_q <= step_q - SW'(1);
                else
                    step_q <= step_q + SW'(1);
            end
        end
    end

    for (genvar j = 0; j < L; j++) begin : g_lane
        lane_select #(
            .N     (N),
            .V     (V),
            .STEPS (STEPS),
            .LANE  (j),
            .SW    (SW)
        ) u_lane (
            .en     (issue),
            .vv     (op_q[OP_VV_BIT]),
            .step   (step_q),
            .a_vec  (a_q),
            .b_vec  (b_q),
            .scalar (scalar_q),
            .a      (Vec_A_o[j]),
            .b      (Vec_B_o[j]),
            .valid  (Lane_Mask_o[j])
        );
    end

    assign Valid_o = issue;
    assign Step_o  = issue ? step_q : '0;
    assign Last_o  = is_last;
    assign Busy_o  = (state_q != ST_IDLE);
    assign Done_o  = (state_q == ST_DONE);

endmodule

// File: tb/tb_vector_fork_seq.sv
module tb_vector_fork_seq;

    logic        CLK;
    logic        RST;
    logic [1:0]  OpType;
    logic [31:0] Scalar_i;
    logic        Ready_i;
    logic        start20, start18, start3;

    logic [31:0] opa [20];
    logic [31:0] opb [20];

    logic [19:0][31:0] rd1_20, rd2_20;
    logic [17:0][31:0] rd1_18, rd2_18;
    logic [2:0][31:0]  rd1_3,  rd2_3;

    for (genvar g = 0; g < 20; g++) begin : g_op20
        assign rd1_20[g] = opa[g];
        assign rd2_20[g] = opb[g];
    end
    for (genvar g = 0; g < 18; g++) begin : g_op18
        assign rd1_18[g] = opa[g];
        assign rd2_18[g] = opb[g];
    end
    for (genvar g = 0; g < 3; g++) begin : g_op3
        assign rd1_3[g] = opa[g];
        assign rd2_3[g] = opb[g];
    end

    logic              v20, l20, bu20, dn20;
    logic [3:0][31:0]  a20, b20;
    logic [3:0]        m20;
    logic [2:0]        st20;
    logic              v18, l18, bu18, dn18;
    logic [3:0][31:0]  a18, b18;
    logic [3:0]        m18;
    logic [2:0]        st18;
    logic              v3, l3, bu3, dn3;
    logic [3:0][31:0]  a3, b3;
    logic [3:0]        m3;
    logic [0:0]        st3;

    vector_fork_seq #(.N(32), .V(20), .L(4)) dut20 (
        .CLK(CLK), .RST(RST), .Start_i(start20), .OpType(OpType),
        .RD1_VEC_i(rd1_20), .RD2_VEC_i(rd2_20), .Scalar_i(Scalar_i), .Ready_i(Ready_i),
        .Valid_o(v20), .Vec_A_o(a20), .Vec_B_o(b20), .Lane_Mask_o(m20), .Step_o(st20),
        .Last_o(l20), .Busy_o(bu20), .Done_o(dn20));

    vector_fork_seq #(.N(32), .V(18), .L(4)) dut18 (
        .CLK(CLK), .RST(RST), .Start_i(start18), .OpType(OpType),
        .RD1_VEC_i(rd1_18), .RD2_VEC_i(rd2_18), .Scalar_i(Scalar_i), .Ready_i(Ready_i),
        .Valid_o(v18), .Vec_A_o(a18), .Vec_B_o(b18), .Lane_Mask_o(m18), .Step_o(st18),
        .Last_o(l18), .Busy_o(bu18), .Done_o(dn18));

    vector_fork_seq #(.N(32), .V(3), .L(4)) dut3 (
        .CLK(CLK), .RST(RST), .Start_i(start3), .OpType(OpType),
        .RD1_VEC_i(rd1_3), .RD2_VEC_i(rd2_3), .Scalar_i(Scalar_i), .Ready_i(Ready_i),
        .Valid_o(v3), .Vec_A_o(a3), .Vec_B_o(b3), .Lane_Mask_o(m3), .Step_o(st3),
        .Last_o(l3), .Busy_o(bu3), .Done_o(dn3));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // observed outputs of the selected instance
    logic [3:0][31:0] o_a, o_b;
    logic [15:0]      o_ctrl;   // {valid, last, busy, done, mask[3:0], step[7:0]}

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample(input int which);
        case (which)
            0: begin o_a = a20; o_b = b20; o_ctrl = {v20, l20, bu20, dn20, m20, 8'(st20)}; end
            1: begin o_a = a18; o_b = b18; o_ctrl = {v18, l18, bu18, dn18, m18, 8'(st18)}; end
            default: begin o_a = a3; o_b = b3; o_ctrl = {v3, l3, bu3, dn3, m3, 8'(st3)}; end
        endcase
    endtask

    function automatic int vlen(input int which);
        return (which == 0) ? 20 : (which == 1) ? 18 : 3;
    endfunction

    // A vector of v elements is split into 4 contiguous chunks of
    // ceil(v/4) elements; lane j walks chunk j one element per step.
    function automatic int nsteps(input int v);
        return (v + 3) / 4;
    endfunction

    function automatic logic [3:0][31:0] m_lanes(input int v, input int s, input bit isb,
                                                 input bit vv);
        logic [3:0][31:0] r;
        int e;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            e = j * nsteps(v) + s;
            if (e < v) r[j[1:0]] = isb ? (vv ? opb[e[4:0]] : Scalar_i) : opa[e[4:0]];
        end
        return r;
    endfunction

    function automatic logic [3:0] m_mask(input int v, input int s);
        logic [3:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) r[j[1:0]] = ((j * nsteps(v) + s) < v);
        return r;
    endfunction

    task automatic set_ramp();
        for (int i = 0; i < 20; i++) begin
            opa[i[4:0]] = 32'(i);
            opb[i[4:0]] = 32'(100 + i);
        end
    endtask

    task automatic set_random();
        for (int i = 0; i < 20; i++) begin
            opa[i[4:0]] = $urandom;
            opb[i[4:0]] = $urandom;
        end
        Scalar_i = $urandom;
    endtask

    // One full sequence on instance `which`; beats with step stall_step get
    // Ready_i low for stall_len cycles before being accepted.
    task automatic run_seq(input int which, input logic [1:0] op, input int stall_step,
                           input int stall_len, input bit rnd);
        int v, steps, k, s, stalled, cyc;
        bit rdy;
        logic [3:0][31:0] ea, eb;
        logic [15:0] ec;
        v = vlen(which);
        steps = nsteps(v);
        OpType = op;
        Ready_i = 1'b0;
        start20 = (which == 0);
        start18 = (which == 1);
        start3  = (which == 2);
        tick();
        start20 = 1'b0; start18 = 1'b0; start3 = 1'b0;
        k = 0; stalled = 0; cyc = 0;
        while (k < steps && cyc < 200) begin
            s  = op[1] ? (steps - 1 - k) : k;
            ea = m_lanes(v, s, 1'b0, op[0]);
            eb = m_lanes(v, s, 1'b1, op[0]);
            ec = {1'b1, (k == steps - 1), 1'b1, 1'b0, m_mask(v, s), 8'(s)};
            sample(which);
            total_cnt++;
            if (o_a !== ea) $display("FAIL beat_A inst=%0d step=%0d got %h exp %h", which, s, o_a, ea);
            else pass_cnt++;
            total_cnt++;
            if (o_b !== eb) $display("FAIL beat_B inst=%0d step=%0d got %h exp %h", which, s, o_b, eb);
            else pass_cnt++;
            total_cnt++;
            if (o_ctrl !== ec) $display("FAIL beat_ctrl inst=%0d step=%0d got %h exp %h", which, s, o_ctrl, ec);
            else pass_cnt++;
            if (s == stall_step && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end else if (rnd) begin
                rdy = ($urandom_range(0, 1) == 1);
            end else begin
                rdy = 1'b1;
            end
            Ready_i = rdy;
            tick();
            if (rdy) k++;
            cyc++;
        end
        total_cnt++;
        if (k != steps) $display("FAIL seq_timeout inst=%0d beats got %0d exp %0d", which, k, steps);
        else pass_cnt++;
        Ready_i = 1'b0;
        sample(which);
        total_cnt++;
        if (o_ctrl !== 16'h3000 || o_a !== '0 || o_b !== '0)
            $display("FAIL done_cycle inst=%0d got ctrl %h exp 3000", which, o_ctrl);
        else pass_cnt++;
        tick();
        sample(which);
        total_cnt++;
        if (o_ctrl !== 16'h0000 || o_a !== '0 || o_b !== '0)
            $display("FAIL back_to_idle inst=%0d got ctrl %h exp 0000", which, o_ctrl);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        start20 = 1'b1; start18 = 1'b1; start3 = 1'b1;
        Ready_i = 1'b1;
        OpType = 2'b11;
        Scalar_i = 32'hdead_beef;
        set_random();
        tick();
        tick();
        for (int w = 0; w < 3; w++) begin
            sample(w);
            total_cnt++;
            if (o_ctrl !== 16'h0000 || o_a !== '0 || o_b !== '0)
                $display("FAIL reset_state inst=%0d got ctrl %h exp 0000", w, o_ctrl);
            else pass_cnt++;
        end
        start20 = 1'b0; start18 = 1'b0; start3 = 1'b0;
        Ready_i = 1'b0;
        RST = 1'b1;
        tick();
    endtask

    task automatic test_vv();
        set_ramp();
        run_seq(0, 2'b01, -1, 0, 1'b0);
    endtask

    task automatic test_vs();
        set_ramp();
        Scalar_i = 32'd7;
        run_seq(0, 2'b00, -1, 0, 1'b0);
    endtask

    task automatic test_stall();
        set_ramp();
        run_seq(0, 2'b01, 2, 3, 1'b0);
    endtask

    task automatic test_reverse();
        set_ramp();
        run_seq(0, 2'b11, -1, 0, 1'b0);
    endtask

    task automatic test_short_vec();
        set_ramp();
        run_seq(1, 2'b01, -1, 0, 1'b0);
        set_random();
        run_seq(1, 2'b10, 4, 2, 1'b1);
    endtask

    task automatic test_single_step();
        set_ramp();
        run_seq(2, 2'b01, -1, 0, 1'b0);
        set_random();
        run_seq(2, 2'b10, 0, 2, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            set_random();
            run_seq($urandom_range(0, 2), 2'($urandom_range(0, 3)), -1, 0, 1'b1);
        end
    endtask

    task automatic test_abort();
        logic [3:0][31:0] ea;
        set_ramp();
        OpType = 2'b01;
        Ready_i = 1'b0;
        start20 = 1'b1;
        tick();
        start20 = 1'b0;
        Ready_i = 1'b1;
        tick(); tick(); tick();
        Ready_i = 1'b0;
        ea = m_lanes(20, 3, 1'b0, 1'b1);
        // new operands and a Start during ISSUE must not disturb the beat
        for (int i = 0; i < 20; i++) opa[i[4:0]] = $urandom;
        OpType = 2'b10;
        start20 = 1'b1;
        tick();
        sample(0);
        total_cnt++;
        if (o_a !== ea) $display("FAIL start_ignored_A got %h exp %h", o_a, ea);
        else pass_cnt++;
        total_cnt++;
        if (o_ctrl !== {4'b1010, 4'b1111, 8'd3})
            $display("FAIL start_ignored_ctrl got %h exp %h", o_ctrl, {4'b1010, 4'b1111, 8'd3});
        else pass_cnt++;
        RST = 1'b0;
        Ready_i = 1'b1;
        tick();
        sample(0);
        total_cnt++;
        if (o_ctrl !== 16'h0000 || o_a !== '0 || o_b !== '0)
            $display("FAIL abort_reset got ctrl %h exp 0000", o_ctrl);
        else pass_cnt++;
        start20 = 1'b0;
        tick();
        sample(0);
        total_cnt++;
        if (o_ctrl !== 16'h0000) $display("FAIL abort_no_done got ctrl %h exp 0000", o_ctrl);
        else pass_cnt++;
        RST = 1'b1;
        Ready_i = 1'b0;
        tick();
        sample(0);
        total_cnt++;
        if (o_ctrl !== 16'h0000) $display("FAIL abort_idle got ctrl %h exp 0000", o_ctrl);
        else pass_cnt++;
    endtask

    initial begin
        RST = 1'b0;
        start20 = 1'b0; start18 = 1'b0; start3 = 1'b0;
        Ready_i = 1'b0;
        OpType = 2'b00;
        Scalar_i = '0;
        for (int i = 0; i < 20; i++) begin
            opa[i[4:0]] = '0;
            opb[i[4:0]] = '0;
        end
        test_reset();
        test_vv();
        test_vs();
        test_stall();
        test_reverse();
        test_short_vec();
        test_single_step();
        test_abort();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
